// File: rtl/ntt_mdc_unload_pkg.sv
// ntt_mdc_unload_pkg
//   Shared definitions for the MDC NTT output unload block:
//   per-bank state encoding used by the ping-pong reorder buffer.
package ntt_mdc_unload_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

endpackage

// File: rtl/bitreverse.sv
// bitreverse
//   Purely combinational bit-order reversal.
//   din_i  : W-bit input word
//   dout_o : din_i with bit i moved to bit W-1-i
module bitreverse #(
    parameter int W = 4
) (
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o
);

    for (genvar i = 0; i < W; i++) begin : g_rev
        assign dout_o[i] = din_i[W-1-i];
    end

endmodule

// File: rtl/ntt_mdc_unload_bank.sv
// ntt_unload_bank
//   Simple dual-port RAM, one write port and one registered read port.
//   clk     : clock
//   we_i    : write enable, waddr_i/wdata_i written at the rising edge
//   re_i    : read enable, rdata_o updated with mem[raddr_i] one cycle later
module ntt_unload_bank #(
    parameter int LOGQ = 64,
    parameter int AW   = 11
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [LOGQ-1:0] wdata_i,
    input  logic            re_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [LOGQ-1:0] rdata_o
);

    logic [LOGQ-1:0] mem_q [2**AW];
    logic [LOGQ-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ntt_mdc_unload.sv
// ntt_mdc_unload
//   Reorders the two-lane bit-reversed output of the last MDC NTT stage into
//   natural order through a ping-pong pair of banks, each split LO/HI.
//
//   state | meaning (per bank)
//   ------+----------------------------------------------------------
//   EMPTY    | free, waiting for the first beat of a frame
//   FILLING  | receiving beats of a frame
//   FULL     | complete frame stored, no read issued yet
//   DRAINING | reads in progress / outputs still pending acceptance
//
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_0/in_1  : one beat from the MDC pipeline (no back-pressure)
//   in_ready            : advisory, write bank can accept a beat
//   overflow            : sticky, a beat arrived while in_ready was low
//   out_valid/out_ready : output handshake
//   out_data/out_idx    : natural-order coefficient and its index
//   out_last            : marks index N-1
//   frame_done          : pulse after the last beat of a frame is written
module ntt_mdc_unload
    import ntt_mdc_unload_pkg::*;
#(
    parameter int LOGQ     = 64,
    parameter int LOGN     = 12,
    parameter int OUT_SKID = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [LOGQ-1:0] in_0,
    input  logic [LOGQ-1:0] in_1,
    output logic            in_ready,
    output logic            overflow,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [LOGQ-1:0] out_data,
    output logic [LOGN-1:0] out_idx,
    output logic            out_last,
    output logic            frame_done
);

    localparam int HW = LOGN - 1;
    localparam int SW = (OUT_SKID > 1) ? $clog2(OUT_SKID) : 1;
    localparam int CW = $clog2(OUT_SKID + 1);

    bank_state_e     state_q [2];
    bank_state_e     state_d [2];
    logic            wr_ptr_q, rd_ptr_q, drain_ptr_q;
    logic [HW-1:0]   beat_cnt_q;
    logic [LOGN-1:0] rd_cnt_q;
    logic            frame_done_q, overflow_q;

    // read in flight: RAM output is valid in the cycle after issue
    logic            rd_vld_q, rd_bank_q, rd_hi_q, rd_last_q;
    logic [LOGN-1:0] rd_idx_q;

    // skid FIFO
    logic [LOGQ-1:0] sk_data_q [OUT_SKID];
    logic [LOGN-1:0] sk_idx_q  [OUT_SKID];
    logic            sk_last_q [OUT_SKID];
    logic [SW-1:0]   sk_head_q, sk_tail_q;
    logic [CW-1:0]   sk_cnt_q;

    logic            accept, beat_last, rd_avail, issue, rd_is_last;
    logic            sk_empty, push, pop, last_accept;
    logic [HW-1:0]   wr_addr;
    logic [LOGQ-1:0] ram_rd [4];
    logic [LOGQ-1:0] rd_word;

    function automatic logic [SW-1:0] sk_next(input logic [SW-1:0] p);
        return (p == SW'(OUT_SKID - 1)) ? '0 : p + SW'(1);
    endfunction

    assign in_ready  = (state_q[wr_ptr_q] == BANK_EMPTY) ||
                       (state_q[wr_ptr_q] == BANK_FILLING);
    assign accept    = in_valid && in_ready;
    assign beat_last = &beat_cnt_q;

    // rd_ptr only ever points at a bank that still has reads to issue
    assign rd_avail   = (state_q[rd_ptr_q] == BANK_FULL) ||
                        (state_q[rd_ptr_q] == BANK_DRAINING);
    assign issue      = rd_avail && ((int'(sk_cnt_q) + int'(rd_vld_q)) < OUT_SKID);
    assign rd_is_last = &rd_cnt_q;

    bitreverse #(.W(HW)) u_wr_addr (
        .din_i  (beat_cnt_q),
        .dout_o (wr_addr)
    );

    for (genvar g = 0; g < 4; g++) begin : g_ram
        localparam bit G_BANK = (g >= 2);
        localparam bit G_HI   = ((g % 2) == 1);
        ntt_unload_bank #(.LOGQ(LOGQ), .AW(HW)) u_ram (
            .clk     (clk),
            .we_i    (accept && (wr_ptr_q == G_BANK)),
            .waddr_i (wr_addr),
            .wdata_i (G_HI ? in_1 : in_0),
            .re_i    (issue && (rd_ptr_q == G_BANK) && (rd_cnt_q[LOGN-1] == G_HI)),
            .raddr_i (rd_cnt_q[HW-1:0]),
            .rdata_o (ram_rd[g])
        );
    end

    assign rd_word = ram_rd[{rd_bank_q, rd_hi_q}];

    // An empty FIFO is bypassed so the RAM word is presented the cycle it arrives.
    assign sk_empty    = (sk_cnt_q == '0);
    assign out_valid   = !sk_empty || rd_vld_q;
    assign out_data    = !out_valid ? '0 : (sk_empty ? rd_word  : sk_data_q[sk_head_q]);
    assign out_idx     = !out_valid ? '0 : (sk_empty ? rd_idx_q : sk_idx_q[sk_head_q]);
    assign out_last    = out_valid && (sk_empty ? rd_last_q : sk_last_q[sk_head_q]);
    assign pop         = !sk_empty && out_ready;
    assign push        = rd_vld_q && !(sk_empty && out_ready);
    assign last_accept = out_valid && out_ready && out_last;

    assign overflow   = overflow_q;
    assign frame_done = frame_done_q;

    // Write, first-read and free events target disjoint states, so at most
    // one of them applies to a given bank in any cycle.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            if (accept && (wr_ptr_q == 1'(b))) begin
                state_d[b] = beat_last ? BANK_FULL : BANK_FILLING;
            end
            if (issue && (rd_ptr_q == 1'(b)) && (state_q[b] == BANK_FULL)) begin
                state_d[b] = BANK_DRAINING;
            end
            if (last_accept && (drain_ptr_q == 1'(b))) begin
                state_d[b] = BANK_EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q[0]   <= BANK_EMPTY;
            state_q[1]   <= BANK_EMPTY;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            drain_ptr_q  <= 1'b0;
            beat_cnt_q   <= '0;
            rd_cnt_q     <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_bank_q    <= 1'b0;
            rd_hi_q      <= 1'b0;
            rd_last_q    <= 1'b0;
            rd_idx_q     <= '0;
            sk_head_q    <= '0;
            sk_tail_q    <= '0;
            sk_cnt_q     <= '0;
        end else begin
            state_q[0]   <= state_d[0];
            state_q[1]   <= state_d[1];
            frame_done_q <= accept && beat_last;
            if (in_valid && !in_ready) begin
                overflow_q <= 1'b1;
            end
            if (accept) begin
                beat_cnt_q <= beat_cnt_q + HW'(1);
                if (beat_last) begin
                    wr_ptr_q <= ~wr_ptr_q;
                end
            end
            // read pointer moves on as soon as the last read is issued,
            // the bank itself is freed later by drain_ptr
            if (issue) begin
                rd_cnt_q <= rd_cnt_q + LOGN'(1);
                if (rd_is_last) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                rd_bank_q <= rd_ptr_q;
                rd_hi_q   <= rd_cnt_q[LOGN-1];
                rd_idx_q  <= rd_cnt_q;
                rd_last_q <= rd_is_last;
            end
            rd_vld_q <= issue;
            if (last_accept) begin
                drain_ptr_q <= ~drain_ptr_q;
            end
            if (push) begin
                sk_tail_q <= sk_next(sk_tail_q);
            end
            if (pop) begin
                sk_head_q <= sk_next(sk_head_q);
            end
            sk_cnt_q <= sk_cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            sk_data_q[sk_tail_q] <= rd_word;
            sk_idx_q[sk_tail_q]  <= rd_idx_q;
            sk_last_q[sk_tail_q] <= rd_last_q;
        end
    end

endmodule

// File: tb/tb_ntt_mdc_unload.sv
module tb_ntt_mdc_unload;

    localparam int LOGQ = 16;
    localparam int LOGN = 4;
    localparam int N    = 16;
    localparam int HALF = 8;

    logic            clk = 1'b0;
    logic            rst, in_valid, out_ready;
    logic [LOGQ-1:0] in_0, in_1;
    logic            in_ready, overflow, out_valid, out_last, frame_done;
    logic [LOGQ-1:0] out_data;
    logic [LOGN-1:0] out_idx;

    always #5 clk = ~clk;

    ntt_mdc_unload #(.LOGQ(LOGQ), .LOGN(LOGN), .OUT_SKID(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_0       (in_0),
        .in_1       (in_1),
        .in_ready   (in_ready),
        .overflow   (overflow),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [3:0] idx0;
        logic [3:0] idx1;
    } beat_vec_t;

    typedef struct {
        logic [LOGQ-1:0] data;
        logic [LOGN-1:0] idx;
        logic            last;
    } out_t;

    beat_vec_t beat_tbl [HALF];
    out_t      exp_q [$];
    out_t      mon_e;

    int n_vec = 0;
    int n_err = 0;
    bit rand_bp = 1'b0;

    int              fd_cnt, run, max_run;
    logic            held_vld;
    logic [LOGQ-1:0] held_data;
    logic [LOGN-1:0] held_idx;
    logic            held_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    endtask

    // output monitor / scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            held_vld = 1'b0;
            run      = 0;
        end else begin
            if (held_vld) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data",  32'(out_data),  32'(held_data));
                check("hold_idx",   32'(out_idx),   32'(held_idx));
                check("hold_last",  32'(out_last),  32'(held_last));
            end
            if (frame_done) fd_cnt++;
            if (out_valid && out_ready) begin
                run++;
                if (run > max_run) max_run = run;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got idx %0d data 0x%0h, required no output",
                             out_idx, out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(mon_e.data));
                    check("out_idx",  32'(out_idx),  32'(mon_e.idx));
                    check("out_last", 32'(out_last), 32'(mon_e.last));
                end
            end else begin
                run = 0;
            end
            held_vld  = out_valid && !out_ready;
            held_data = out_data;
            held_idx  = out_idx;
            held_last = out_last;
        end
    end

    task automatic send_frame(input int tag, input bit obey, input bit keep,
                              input int nbeats, input bit chk_rdy);
        for (int k = 0; k < nbeats; k++) begin
            if (obey) begin
                int w = 0;
                while (!in_ready && w < 300) begin
                    tick();
                    w++;
                end
                if (w >= 300) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL in_ready_wait: in_ready still 0 after %0d cycles, required 1", w);
                end
            end
            if (chk_rdy) check("in_ready_beat", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_0 = 16'(tag * 256 + int'(beat_tbl[k].idx0));
            in_1 = 16'(tag * 256 + int'(beat_tbl[k].idx1));
            tick();
        end
        in_valid = 1'b0;
        if (keep) begin
            for (int j = 0; j < N; j++) begin
                exp_q.push_back('{data: 16'(tag * 256 + j), idx: 4'(j), last: (j == N - 1)});
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            tick();
            c++;
        end
        check("drain_complete", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        tick();
        check("rst_in_ready",   32'(in_ready),   32'd1);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_overflow",   32'(overflow),   32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_out_last",   32'(out_last),   32'd0);
        check("rst_out_data",   32'(out_data),   32'd0);
        check("rst_out_idx",    32'(out_idx),    32'd0);
        rst = 1'b0;
    endtask

    initial begin
        // beat k carries bitrev4(2k) on lane 0 and bitrev4(2k+1) on lane 1
        beat_tbl[0] = '{idx0: 4'd0, idx1: 4'd8};
        beat_tbl[1] = '{idx0: 4'd4, idx1: 4'd12};
        beat_tbl[2] = '{idx0: 4'd2, idx1: 4'd10};
        beat_tbl[3] = '{idx0: 4'd6, idx1: 4'd14};
        beat_tbl[4] = '{idx0: 4'd1, idx1: 4'd9};
        beat_tbl[5] = '{idx0: 4'd5, idx1: 4'd13};
        beat_tbl[6] = '{idx0: 4'd3, idx1: 4'd11};
        beat_tbl[7] = '{idx0: 4'd7, idx1: 4'd15};

        rst = 1'b1; in_valid = 1'b0; in_0 = '0; in_1 = '0; out_ready = 1'b0;
        fd_cnt = 0; run = 0; max_run = 0; held_vld = 1'b0;
        tick();
        tick();
        do_reset();

        // natural-order frame, data == index
        out_ready = 1'b1;
        fd_cnt = 0;
        send_frame(0, 1'b0, 1'b1, HALF, 1'b1);
        check("latency_frame_done", 32'(frame_done), 32'd1);
        check("latency_t1_valid",   32'(out_valid),  32'd0);
        tick();
        check("latency_t2_valid",   32'(out_valid),  32'd1);
        check("latency_t2_idx",     32'(out_idx),    32'd0);
        check("frame_done_pulse",   32'(frame_done), 32'd0);
        wait_drain(100);
        tick();
        check("frame_done_count", 32'(fd_cnt), 32'd1);
        check("idle_after_drain", 32'(out_valid), 32'd0);

        // random back-pressure over three frames
        rand_bp = 1'b1;
        send_frame(1, 1'b1, 1'b1, HALF, 1'b0);
        send_frame(2, 1'b1, 1'b1, HALF, 1'b0);
        send_frame(3, 1'b1, 1'b1, HALF, 1'b0);
        wait_drain(2000);
        rand_bp = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

        // ping-pong overlap: second frame streams while first drains
        max_run = 0;
        send_frame(4, 1'b0, 1'b1, HALF, 1'b1);
        send_frame(5, 1'b0, 1'b1, HALF, 1'b1);
        wait_drain(200);
        tick();
        check("gapless_run", 32'(max_run), 32'd32);

        // overflow: consumer stalled, third frame has nowhere to go
        out_ready = 1'b0;
        send_frame(6, 1'b0, 1'b1, HALF, 1'b1);
        send_frame(7, 1'b0, 1'b1, HALF, 1'b1);
        check("ovf_in_ready_low", 32'(in_ready), 32'd0);
        check("ovf_flag_before",  32'(overflow), 32'd0);
        send_frame(8, 1'b0, 1'b0, 5, 1'b0);
        check("ovf_flag_set",     32'(overflow), 32'd1);
        check("ovf_in_ready_still_low", 32'(in_ready), 32'd0);
        for (int i = 0; i < 10; i++) tick();
        out_ready = 1'b1;
        wait_drain(300);
        // dropped beats must not have moved the beat counter
        send_frame(9, 1'b1, 1'b1, HALF, 1'b0);
        wait_drain(300);
        check("ovf_sticky", 32'(overflow), 32'd1);
        do_reset();

        // reset after beat 5 of a frame
        send_frame(10, 1'b0, 1'b0, 6, 1'b0);
        do_reset();
        send_frame(11, 1'b0, 1'b1, HALF, 1'b1);
        wait_drain(200);

        // reset while output index 9 is presented
        send_frame(12, 1'b0, 1'b1, HALF, 1'b0);
        begin
            int c = 0;
            while (!(out_valid && out_idx == 4'd9) && c < 200) begin
                tick();
                c++;
            end
        end
        check("reach_idx9", 32'({out_valid, out_idx}), 32'({1'b1, 4'd9}));
        do_reset();
        send_frame(13, 1'b0, 1'b1, HALF, 1'b1);
        wait_drain(200);
        tick();
        check("final_idle", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
